// File: rtl/id_ctrl_stage.sv
// RV32I decode/control stage: decodes into ID/EX register with valid/ready, load-use scoreboard, flush.
// Optional performance counters (stall_cnt, flush_cnt) are enabled by defining ID_PERF_CNT_EN.
module id_ctrl_stage #(
  parameter int PC_W     = 32,
  parameter int LOAD_LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_ExtOp,
  output logic [2:0]      out_Branch,
  output logic [1:0]      out_ALUBSrc,
  output logic [3:0]      out_ALUctr,
  output logic [2:0]      out_MemOp,
  output logic            out_RegWr,
  output logic            out_MemtoReg,
  output logic            out_ALUASrc,
  output logic            out_MemWr,
  output logic            out_illegal,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
);

  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;

  typedef struct packed {
    logic [2:0] ext_op;
    logic [2:0] branch;
    logic [1:0] alu_bsrc;
    logic [3:0] alu_ctr;
    logic [2:0] mem_op;
    logic       reg_wr;
    logic       mem_to_reg;
    logic       alu_asrc;
    logic       mem_wr;
    logic       illegal;
  } ctrl_t;

  logic [4:0] op;
  logic [2:0] func3;
  logic       func7;
  logic [4:0] rs1, rs2, rd;
  logic       unused_instr_bits;

  assign op    = in_instr[6:2];
  assign func3 = in_instr[14:12];
  assign func7 = in_instr[30];
  assign rs1   = in_instr[19:15];
  assign rs2   = in_instr[24:20];
  assign rd    = in_instr[11:7];
  assign unused_instr_bits = ^{in_instr[31], in_instr[29:25], in_instr[1:0]};

  ctrl_t ctrl_d;
  logic  legal;
  logic  rs1_use, rs2_use;

  always_comb begin
    ctrl_d  = '0;
    legal   = 1'b1;
    rs1_use = 1'b0;
    rs2_use = 1'b0;
    case (op)
      OP_LUI: begin
        ctrl_d.ext_op   = 3'b001;
        ctrl_d.reg_wr   = 1'b1;
        ctrl_d.alu_bsrc = 2'b01;
        ctrl_d.alu_ctr  = 4'b1111;
      end
      OP_AUIPC: begin
        ctrl_d.ext_op   = 3'b001;
        ctrl_d.reg_wr   = 1'b1;
        ctrl_d.alu_asrc = 1'b1;
        ctrl_d.alu_bsrc = 2'b01;
      end
      OP_IMM: begin
        rs1_use         = 1'b1;
        ctrl_d.reg_wr   = 1'b1;
        ctrl_d.alu_bsrc = 2'b01;
        // only the shift-right group distinguishes logical/arithmetic via func7
        ctrl_d.alu_ctr  = (func3 == 3'b101) ? {func7, func3} : {1'b0, func3};
      end
      OP_OP: begin
        rs1_use        = 1'b1;
        rs2_use        = 1'b1;
        ctrl_d.reg_wr  = 1'b1;
        ctrl_d.alu_ctr = {func7, func3};
      end
      OP_JAL: begin
        ctrl_d.ext_op   = 3'b100;
        ctrl_d.reg_wr   = 1'b1;
        ctrl_d.branch   = 3'b001;
        ctrl_d.alu_asrc = 1'b1;
        ctrl_d.alu_bsrc = 2'b10;
      end
      OP_JALR: begin
        rs1_use         = 1'b1;
        ctrl_d.reg_wr   = 1'b1;
        ctrl_d.branch   = 3'b010;
        ctrl_d.alu_asrc = 1'b1;
        ctrl_d.alu_bsrc = 2'b10;
      end
      OP_BRANCH: begin
        rs1_use        = 1'b1;
        rs2_use        = 1'b1;
        ctrl_d.ext_op  = 3'b011;
        ctrl_d.alu_ctr = (func3[2:1] == 2'b11) ? 4'b0011 : 4'b0010;
        case (func3)
          3'b000:         ctrl_d.branch = 3'b100;
          3'b001:         ctrl_d.branch = 3'b101;
          3'b100, 3'b110: ctrl_d.branch = 3'b110;
          3'b101, 3'b111: ctrl_d.branch = 3'b111;
          default:        legal = 1'b0;
        endcase
      end
      OP_LOAD: begin
        rs1_use           = 1'b1;
        ctrl_d.reg_wr     = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.alu_bsrc   = 2'b01;
        case (func3)
          3'b000:  ctrl_d.mem_op = 3'b001;
          3'b001:  ctrl_d.mem_op = 3'b010;
          3'b010:  ctrl_d.mem_op = 3'b000;
          3'b100:  ctrl_d.mem_op = 3'b101;
          3'b101:  ctrl_d.mem_op = 3'b110;
          default: legal = 1'b0;
        endcase
      end
      OP_STORE: begin
        rs1_use         = 1'b1;
        rs2_use         = 1'b1;
        ctrl_d.ext_op   = 3'b010;
        ctrl_d.mem_wr   = 1'b1;
        ctrl_d.alu_bsrc = 2'b01;
        case (func3)
          3'b000:  ctrl_d.mem_op = 3'b001;
          3'b001:  ctrl_d.mem_op = 3'b010;
          3'b010:  ctrl_d.mem_op = 3'b000;
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    // illegal instructions still flow to EX, but must not write anything
    if (!legal) begin
      ctrl_d         = '0;
      ctrl_d.illegal = 1'b1;
      rs1_use        = 1'b0;
      rs2_use        = 1'b0;
    end
  end

  ctrl_t           ctrl_q;
  logic            out_valid_q, out_valid_d;
  logic [PC_W-1:0] pc_q;
  logic [4:0]      rs1_q, rs2_q, rd_q;
  logic [LOAD_LAT-1:0] sb_vld_q;
  logic [4:0]          sb_rd_q [LOAD_LAT];

  logic rs1_hit, rs2_hit, hazard, accept, out_hs;

  always_comb begin
    rs1_hit = out_valid_q && ctrl_q.mem_to_reg && (rd_q == rs1);
    rs2_hit = out_valid_q && ctrl_q.mem_to_reg && (rd_q == rs2);
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (sb_vld_q[i] && (sb_rd_q[i] == rs1)) rs1_hit = 1'b1;
      if (sb_vld_q[i] && (sb_rd_q[i] == rs2)) rs2_hit = 1'b1;
    end
  end

  assign hazard   = in_valid && ((rs1_use && (rs1 != 5'd0) && rs1_hit) ||
                                 (rs2_use && (rs2 != 5'd0) && rs2_hit));
  assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    if (flush)       out_valid_d = 1'b0;
    else if (accept) out_valid_d = 1'b1;
    else if (out_hs) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      pc_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (accept) begin
        ctrl_q <= ctrl_d;
        pc_q   <= in_pc;
        rs1_q  <= rs1;
        rs2_q  <= rs2;
        rd_q   <= rd;
      end
    end
  end

  // flush leaves the scoreboard alone: loads already handed to EX are older than the branch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_vld_q <= '0;
      for (int i = 0; i < LOAD_LAT; i++) sb_rd_q[i] <= '0;
    end else begin
      sb_vld_q[0] <= out_hs && ctrl_q.mem_to_reg;
      sb_rd_q[0]  <= (out_hs && ctrl_q.mem_to_reg) ? rd_q : 5'd0;
      for (int i = 1; i < LOAD_LAT; i++) begin
        sb_vld_q[i] <= sb_vld_q[i-1];
        sb_rd_q[i]  <= sb_rd_q[i-1];
      end
    end
  end

`ifdef ID_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hazard)               stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush && out_valid_q) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

  assign out_valid    = out_valid_q;
  assign out_pc       = pc_q;
  assign out_rs1      = rs1_q;
  assign out_rs2      = rs2_q;
  assign out_rd       = rd_q;
  assign out_ExtOp    = ctrl_q.ext_op;
  assign out_Branch   = ctrl_q.branch;
  assign out_ALUBSrc  = ctrl_q.alu_bsrc;
  assign out_ALUctr   = ctrl_q.alu_ctr;
  assign out_MemOp    = ctrl_q.mem_op;
  assign out_RegWr    = ctrl_q.reg_wr;
  assign out_MemtoReg = ctrl_q.mem_to_reg;
  assign out_ALUASrc  = ctrl_q.alu_asrc;
  assign out_MemWr    = ctrl_q.mem_wr;
  assign out_illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Directed bench for id_ctrl_stage: decode vectors, load-use stall, back-pressure, flush, reset.
module tb_id_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [2:0]  out_ExtOp, out_Branch, out_MemOp;
  logic [1:0]  out_ALUBSrc;
  logic [3:0]  out_ALUctr;
  logic        out_RegWr, out_MemtoReg, out_ALUASrc, out_MemWr, out_illegal;
  logic [31:0] stall_cnt, flush_cnt;

  int tests = 0;
  int fails = 0;

`ifdef ID_PERF_CNT_EN
  localparam int EXP_STALL = 3;
  localparam int EXP_FLUSH = 1;
`else
  localparam int EXP_STALL = 0;
  localparam int EXP_FLUSH = 0;
`endif

  id_ctrl_stage #(.PC_W(32), .LOAD_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_ExtOp(out_ExtOp), .out_Branch(out_Branch), .out_ALUBSrc(out_ALUBSrc),
    .out_ALUctr(out_ALUctr), .out_MemOp(out_MemOp),
    .out_RegWr(out_RegWr), .out_MemtoReg(out_MemtoReg), .out_ALUASrc(out_ALUASrc),
    .out_MemWr(out_MemWr), .out_illegal(out_illegal),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // {ExtOp, Branch, ALUBSrc, ALUctr, MemOp, RegWr, MemtoReg, ALUASrc, MemWr, illegal}
  function automatic logic [19:0] ctl();
    return {out_ExtOp, out_Branch, out_ALUBSrc, out_ALUctr, out_MemOp,
            out_RegWr, out_MemtoReg, out_ALUASrc, out_MemWr, out_illegal};
  endfunction

  function automatic logic [19:0] mk(input logic [2:0] ext, input logic [2:0] br,
                                     input logic [1:0] bsrc, input logic [3:0] aluc,
                                     input logic [2:0] memop, input logic rw, input logic m2r,
                                     input logic asrc, input logic mw, input logic ill);
    return {ext, br, bsrc, aluc, memop, rw, m2r, asrc, mw, ill};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
    #1;
  endtask

  task automatic decode(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                        input logic [19:0] exp_ctl, input logic [4:0] exp_rd);
    drive(1'b1, instr, pc);
    check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    cyc();
    in_valid = 1'b0;
    check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".ctl"}, {12'd0, ctl()}, {12'd0, exp_ctl});
    check({tag, ".rd"}, {27'd0, out_rd}, {27'd0, exp_rd});
    check({tag, ".pc"}, out_pc, pc);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
    cyc(); cyc();
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.ctl", {12'd0, ctl()}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst.in_ready", {31'd0, in_ready}, 32'd1);
    cyc();

    decode("addi",  32'h00500093, 32'h100, mk(3'b000, 3'b000, 2'b01, 4'b0000, 3'b000, 1, 0, 0, 0, 0), 5'd1);
    decode("lui",   32'h12345137, 32'h104, mk(3'b001, 3'b000, 2'b01, 4'b1111, 3'b000, 1, 0, 0, 0, 0), 5'd2);
    decode("jal",   32'h000000EF, 32'h108, mk(3'b100, 3'b001, 2'b10, 4'b0000, 3'b000, 1, 0, 1, 0, 0), 5'd1);
    decode("sw",    32'h00512223, 32'h10C, mk(3'b010, 3'b000, 2'b01, 4'b0000, 3'b000, 0, 0, 0, 1, 0), 5'd4);
    decode("srai",  32'h4030D213, 32'h110, mk(3'b000, 3'b000, 2'b01, 4'b1101, 3'b000, 1, 0, 0, 0, 0), 5'd4);
    decode("sub",   32'h404183B3, 32'h114, mk(3'b000, 3'b000, 2'b00, 4'b1000, 3'b000, 1, 0, 0, 0, 0), 5'd7);
    decode("sltiu", 32'h0010B193, 32'h118, mk(3'b000, 3'b000, 2'b01, 4'b0011, 3'b000, 1, 0, 0, 0, 0), 5'd3);
    decode("bltu",  32'h0020E063, 32'h11C, mk(3'b011, 3'b110, 2'b00, 4'b0011, 3'b000, 0, 0, 0, 0, 0), 5'd0);
    decode("ill7f", 32'h0000207F, 32'h120, mk(3'b000, 3'b000, 2'b00, 4'b0000, 3'b000, 0, 0, 0, 0, 1), 5'd0);
    decode("ldf3",  32'h00013283, 32'h124, mk(3'b000, 3'b000, 2'b00, 4'b0000, 3'b000, 0, 0, 0, 0, 1), 5'd5);
    cyc();
    check("idle.out_valid", {31'd0, out_valid}, 32'd0);

    // load-use: lw x5,0(x2) followed by add x6,x5,x1
    drive(1'b1, 32'h00012283, 32'h130);
    cyc();
    check("lw.ctl", {12'd0, ctl()}, {12'd0, mk(3'b000, 3'b000, 2'b01, 4'b0000, 3'b000, 1, 1, 0, 0, 0)});
    drive(1'b1, 32'h00128333, 32'h134);
    check("lu.c1.in_ready", {31'd0, in_ready}, 32'd0);
    cyc();
    check("lu.c2.out_valid", {31'd0, out_valid}, 32'd0);
    check("lu.c2.in_ready", {31'd0, in_ready}, 32'd0);
    cyc();
    check("lu.c3.in_ready", {31'd0, in_ready}, 32'd0);
    cyc();
    check("lu.c4.in_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    in_valid = 1'b0;
    check("lu.add.out_valid", {31'd0, out_valid}, 32'd1);
    check("lu.add.pc", out_pc, 32'h134);
    check("lu.add.rs1", {27'd0, out_rs1}, 32'd5);
    check("lu.stall_cnt", stall_cnt, EXP_STALL);

    // x0 destination never stalls; imm bits matching rd in rs2 field of addi do not stall
    drive(1'b1, 32'h00012003, 32'h140);
    cyc();
    drive(1'b1, 32'h00100333, 32'h144);
    check("x0.in_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    drive(1'b1, 32'h00012283, 32'h148);
    cyc();
    drive(1'b1, 32'h00508393, 32'h14C);
    check("rs2unused.in_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    in_valid = 1'b0;
    check("rs2unused.rd", {27'd0, out_rd}, 32'd7);
    check("nostall.stall_cnt", stall_cnt, EXP_STALL);
    cyc(); cyc(); cyc();

    // back-pressure
    out_ready = 1'b0;
    drive(1'b1, 32'h00500093, 32'h200);
    cyc();
    drive(1'b1, 32'h12345137, 32'h204);
    for (int i = 0; i < 4; i++) begin
      check("bp.in_ready", {31'd0, in_ready}, 32'd0);
      check("bp.out_pc", out_pc, 32'h200);
      check("bp.out_rd", {27'd0, out_rd}, 32'd1);
      cyc();
    end
    out_ready = 1'b1;
    #1;
    check("bp.release.in_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    check("bp.hs1.pc", out_pc, 32'h204);
    drive(1'b1, 32'h000000EF, 32'h208);
    check("bp.hs2.in_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    in_valid = 1'b0;
    check("bp.hs2.pc", out_pc, 32'h208);
    cyc();
    check("bp.drain.out_valid", {31'd0, out_valid}, 32'd0);
    check("bp.stall_cnt", stall_cnt, EXP_STALL);

    // flush with a beq held and sub waiting
    out_ready = 1'b0;
    drive(1'b1, 32'h00208063, 32'h300);
    cyc();
    drive(1'b1, 32'h404183B3, 32'h304);
    flush = 1'b1;
    #1;
    check("fl.in_ready", {31'd0, in_ready}, 32'd0);
    cyc();
    flush = 1'b0;
    out_ready = 1'b1;
    #1;
    check("fl.out_valid", {31'd0, out_valid}, 32'd0);
    check("fl.flush_cnt", flush_cnt, EXP_FLUSH);
    check("fl.after.in_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    in_valid = 1'b0;
    check("fl.sub.pc", out_pc, 32'h304);
    check("fl.sub.alu", {28'd0, out_ALUctr}, 32'h8);

    // asynchronous reset while holding a valid instruction
    out_ready = 1'b0;
    drive(1'b1, 32'h00500093, 32'h400);
    cyc();
    in_valid = 1'b0;
    check("mrst.pre.out_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mrst.out_valid", {31'd0, out_valid}, 32'd0);
    check("mrst.ctl", {12'd0, ctl()}, 32'd0);
    check("mrst.pc", out_pc, 32'd0);
    check("mrst.rd", {27'd0, out_rd}, 32'd0);
    check("mrst.stall_cnt", stall_cnt, 32'd0);
    check("mrst.flush_cnt", flush_cnt, 32'd0);
    cyc();
    rst_n = 1'b1;
    #1;
    check("mrst.in_ready", {31'd0, in_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
